// File: rtl/rand_arbiter.sv
// Round-robin arbiter that serves one requester at a time and returns a
// random value in [0, range) drawn from an 8-bit LFSR by masked rejection sampling.
`timescale 1ns/1ps
module rand_arbiter #(
   parameter logic [7:0] SEED      = 8'd1,
   parameter int         MAX_TRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] range_i,
   output logic [3:0]  grant,
   output logic        valid,
   output logic [7:0]  rand_o,
   output logic        busy
);

   localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic [7:0]    lfsr_shift;
   logic [1:0]    idx_q, idx_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [7:0]    range_q, range_d;
   logic [7:0]    mask_q, mask_d;
   logic [TW-1:0] try_q, try_d;
   logic [7:0]    rand_q, rand_d;

   logic [7:0]    range_arr [4];
   logic [1:0]    sel_idx;
   logic [1:0]    rr_idx;
   logic [7:0]    candidate;
   logic          accept;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign range_arr[gi] = range_i[8*gi +: 8];
         assign grant[gi]     = valid && (idx_q == 2'(gi));
      end
   endgenerate

   // Range 0 wraps to 8'hFF before smearing, which yields the full mask.
   function automatic logic [7:0] mask_of(input logic [7:0] r);
      logic [7:0] x;
      x = r - 8'd1;
      x = x | (x >> 1);
      x = x | (x >> 2);
      x = x | (x >> 4);
      return x;
   endfunction

   always_comb begin
      lfsr_shift = {lfsr_q[4] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0], lfsr_q[7:1]};
      if (lfsr_q == 8'h00) begin
         lfsr_d = 8'hFF;
      end else if (lfsr_shift == 8'hFF) begin
         lfsr_d = 8'h00;
      end else begin
         lfsr_d = lfsr_shift;
      end
   end

   // Scan from the highest offset down so the lowest offset from ptr_q wins.
   always_comb begin
      sel_idx = ptr_q;
      rr_idx  = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         rr_idx = ptr_q + 2'(i);
         if (req[rr_idx]) begin
            sel_idx = rr_idx;
         end
      end
   end

   assign candidate = lfsr_q & mask_q;
   assign accept    = (range_q == 8'd0) || (candidate < range_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      range_d = range_q;
      mask_d  = mask_q;
      try_d   = try_q;
      rand_d  = rand_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               idx_d   = sel_idx;
               range_d = range_arr[sel_idx];
               mask_d  = mask_of(range_arr[sel_idx]);
               try_d   = '0;
               state_d = DRAW;
            end
         end
         DRAW: begin
            if (accept) begin
               rand_d  = candidate;
               state_d = DONE;
            end else if (try_q == LAST_TRY) begin
               rand_d  = 8'd0;
               state_d = DONE;
            end else begin
               try_d = try_q + TW'(1);
            end
         end
         DONE: begin
            ptr_d   = idx_q + 2'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= SEED;
         idx_q   <= 2'd0;
         ptr_q   <= 2'd0;
         range_q <= 8'd0;
         mask_q  <= 8'd0;
         try_q   <= '0;
         rand_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         range_q <= range_d;
         mask_q  <= mask_d;
         try_q   <= try_d;
         rand_q  <= rand_d;
      end
   end

   assign valid  = (state_q == DONE);
   assign busy   = (state_q != IDLE);
   assign rand_o = rand_q;

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 SHALL have parameter SEED, default 8'd1, giving the LFSR value loaded on reset.
REQ-002 SHALL have parameter MAX_TRIES, default 16, giving the maximum number of draw cycles per request before fallback.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 4 bits: per-requester request level.
REQ-006 SHALL have port range_i, input, 32 bits: four packed 8-bit ranges, requester n at [8n+7:8n]; 0 means 256.
REQ-007 SHALL have port grant, output, 4 bits: one-hot, one-cycle pulse identifying the served requester.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse coincident with grant.
REQ-009 SHALL have port rand_o, output, 8 bits: random value, held until the next valid.
REQ-010 SHALL have port busy, output, 1 bit: high while the FSM is not IDLE.

Function
REQ-011 SHALL contain an 8-bit LFSR that steps on every clock edge outside reset with this rule: if value is 0, next is 8'hFF; else next is {r[4]^r[3]^r[2]^r[0], r[7:1]}, and a result of 8'hFF is replaced by 0.
REQ-012 SHALL implement FSM states IDLE, DRAW and DONE.
REQ-013 In IDLE with req nonzero, SHALL select one requester round-robin, starting at the index after the last granted one (index 0 after reset), SHALL latch its index and range, and SHALL go to DRAW.
REQ-014 On entering DRAW, SHALL clear the try counter and SHALL compute mask = smallest 2^k-1 >= range-1, with range 0 giving mask 8'hFF and range 1 giving mask 8'h00.
REQ-015 In each DRAW cycle, SHALL form candidate = current LFSR value & mask.
REQ-016 In DRAW, SHALL accept the candidate when range is 0 or candidate < range, by loading rand_o and going to DONE.
REQ-017 In DRAW, SHALL otherwise increment the try counter.
REQ-018 When the try counter reaches MAX_TRIES-1 without acceptance, SHALL load rand_o = 0 and go to DONE.
REQ-019 In DONE, SHALL assert valid and grant[idx] for exactly one cycle and SHALL then return to IDLE.
REQ-020 SHALL give a minimum latency of 2 edges from the IDLE sampling edge to the edge after which valid is high, and a maximum of MAX_TRIES+1 edges.
REQ-021 SHALL sample req only in IDLE; a latched request SHALL be served even if its req drops.
REQ-022 Requests arriving during DRAW or DONE SHALL wait; a requester still holding req after its grant SHALL be re-arbitrated normally.
REQ-023 SHALL not let a change of range_i during DRAW affect the latched range.
REQ-024 SHALL never assert more than one grant bit, and SHALL keep grant at 0 when valid is low.
REQ-025 SHALL ensure every accepted rand_o is less than the latched range, or is 0 on fallback.

Reset
REQ-026 On rst high, SHALL immediately set state IDLE, LFSR = SEED, rand_o = 0, valid = 0, grant = 0, busy = 0 and round-robin pointer = 0.
REQ-027 A reset asserted mid-DRAW or mid-DONE SHALL abort the request without emitting valid.
REQ-028 After rst falls, the first edge SHALL step the LFSR and MAY sample req.

Verification
REQ-029 Bench SHALL cover: SEED=1, req=4'b0001, range0=0 from the first edge after reset -> the LFSR runs 01,80,40,20,10,88; valid and grant=4'b0001 pulse with rand_o=8'h80.
REQ-030 Bench SHALL cover: req=4'b1111 held with all ranges 0 -> grants in order 0001,0010,0100,1000,0001, each valid exactly one cycle, never overlapping.
REQ-031 Bench SHALL cover: range=1 -> rand_o=0 at minimum latency; range=5 over 1000 requests -> all rand_o in 0..4, every value seen.
REQ-032 Bench SHALL cover: MAX_TRIES=2 with a seed/range chosen so both draws reject -> fallback rand_o=0 at latency MAX_TRIES+1.
REQ-033 Bench SHALL cover: rst pulsed while busy=1 -> valid stays 0, outputs are at reset values asynchronously, and the next request is served from pointer 0.
REQ-034 Bench SHALL cover: req dropped one cycle after sampling, and range_i changed during DRAW -> grant still issued, and rand_o respects the originally latched range.
